stream_arbiter: RTL and testbench

STREAM_ARBITER -- requirements
Module: stream_arbiter

---
 rtl/stream_arbiter.sv | 141 ++++++++++++++
 tb/tb_stream_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Round-robin CHANNELS:1 stream arbiter built on a three-state IDLE/ACCEPT/SEND handshake FSM.
// Optional output-stall watchdog is enabled by defining STREAM_ARBITER_WATCHDOG_EN.
module stream_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        exception,
    input  logic [CHANNELS*WIDTH-1:0]   input_data,
    input  logic [CHANNELS-1:0]         input_data_stb,
    output logic [CHANNELS-1:0]         input_data_ack,
    output logic [WIDTH-1:0]            output_data,
    output logic [$clog2(CHANNELS)-1:0] output_channel,
    output logic                        output_data_stb,
    input  logic                        output_data_ack
);

    localparam int unsigned CW = $clog2(CHANNELS);

    if (CHANNELS < 2 || CHANNELS > 16 || TIMEOUT == 0) begin : g_bad_params
        $error("stream_arbiter: illegal CHANNELS or TIMEOUT");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StSend
    } state_e;

    state_e            state;
    logic [CW-1:0]     pointer;
    logic [CW-1:0]     grant;
    logic [CW-1:0]     pick;
    logic [CW-1:0]     idx;
    logic              found;
    logic [CHANNELS-1:0] ack_onehot;
    logic [WIDTH-1:0]  chan_data [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            chan_data[c] = input_data[c*WIDTH +: WIDTH];
        end
    end

    // First requester at or above the pointer, wrapping past the top channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = CW'((32'(pointer) + 32'(i)) % CHANNELS);
            if (!found && input_data_stb[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        ack_onehot       = '0;
        ack_onehot[pick] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            pointer         <= '0;
            grant           <= '0;
            input_data_ack  <= '0;
            output_data     <= '0;
            output_channel  <= '0;
            output_data_stb <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (found) begin
                        grant          <= pick;
                        input_data_ack <= ack_onehot;
                        state          <= StAccept;
                    end
                end
                StAccept: begin
                    input_data_ack <= '0;
                    if (input_data_stb[grant]) begin
                        output_data     <= chan_data[grant];
                        output_channel  <= grant;
                        output_data_stb <= 1'b1;
                        state           <= StSend;
                    end else begin
                        // Requester withdrew: no transfer, pointer untouched.
                        state <= StIdle;
                    end
                end
                StSend: begin
                    if (output_data_ack) begin
                        output_data_stb <= 1'b0;
                        pointer         <= (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
                        state           <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef STREAM_ARBITER_WATCHDOG_EN
    logic [31:0] wd_count;
    logic [31:0] wd_next;

    // Saturating stall counter; cleared by every output transfer.
    always_comb begin
        wd_next = wd_count;
        if (state == StSend) begin
            if (output_data_ack) begin
                wd_next = '0;
            end else if (wd_count != '1) begin
                wd_next = wd_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_count  <= '0;
            exception <= 1'b0;
        end else begin
            wd_count <= wd_next;
            if (wd_next >= TIMEOUT) begin
                exception <= 1'b1;
            end
        end
    end
`else
    assign exception = 1'b0;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level round-robin reference model.
module tb_stream_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;
`ifdef STREAM_ARBITER_WATCHDOG_EN
    localparam logic WdEn = 1'b1;
`else
    localparam logic WdEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           exc;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   stb;
    logic [N-1:0]   iack;
    logic [W-1:0]   odata;
    logic [1:0]     och;
    logic           ostb;
    logic           oack;
    logic [W-1:0]   words [N];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = words[i];
    end

    stream_arbiter #(
        .WIDTH(W),
        .CHANNELS(N),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .exception(exc),
        .input_data(in_data),
        .input_data_stb(stb),
        .input_data_ack(iack),
        .output_data(odata),
        .output_channel(och),
        .output_data_stb(ostb),
        .output_data_ack(oack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] chan_word(input int n);
        return (n == 2) ? 32'h1234_5678 : 32'hA0 + 32'(n);
    endfunction

    // Reference model: round-robin pointer, pending grant and a one-deep held-word queue.
    typedef struct {
        int         ch;
        logic [W-1:0] data;
    } word_t;

    int    m_ptr;
    int    m_grant;
    word_t held_q[$];

    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_grant = -1;
        held_q.delete();
    endtask

    task automatic model_edge();
        if (held_q.size() != 0) begin
            if (oack) begin
                m_ptr = (held_q[0].ch + 1) % N;
                void'(held_q.pop_front());
            end
        end else if (m_grant >= 0) begin
            if (stb[m_grant]) held_q.push_back('{m_grant, words[m_grant]});
            m_grant = -1;
        end else if (stb != '0) begin
            m_grant = rr_pick(m_ptr, stb);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        stb  = '0;
        oack = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [N-1:0] stb;
        logic         oack;
        logic [N-1:0] exp_iack;
        logic         exp_ostb;
        logic [1:0]   exp_ch;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [W-1:0] held_data;
        logic [1:0]   held_ch;
        int           got_ch   [6];
        int           got_cyc  [6];
        int           ngot;
        logic [N-1:0] exp_iack;

        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
        vecs[2]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2};
        vecs[3]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[4]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0};
        vecs[5]  = '{4'b1001, 1'b1, 4'b0000, 1'b1, 2'd3};
        vecs[6]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[7]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[10] = '{4'b1011, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[11] = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[14] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[15] = '{4'b0001, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset state
        rst  = 1'b1;
        stb  = '0;
        oack = 1'b0;
        for (int i = 0; i < N; i++) words[i] = chan_word(i);
        #22;
        check("rst_iack", iack, 0);
        check("rst_ostb", ostb, 0);
        check("rst_odata", odata, 0);
        check("rst_och", och, 0);
        check("rst_exc", exc, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            stb  = vecs[v].stb;
            oack = vecs[v].oack;
            step();
            check($sformatf("vec%0d_iack", v), iack, vecs[v].exp_iack);
            check($sformatf("vec%0d_ostb", v), ostb, vecs[v].exp_ostb);
            if (vecs[v].exp_ostb) begin
                check($sformatf("vec%0d_och", v), och, vecs[v].exp_ch);
                check($sformatf("vec%0d_odata", v), odata, chan_word(int'(vecs[v].exp_ch)));
            end
        end

        // All channels requesting: strict rotation, one word per 3 cycles
        do_reset();
        for (int i = 0; i < N; i++) words[i] = 32'hA0 + 32'(i);
        stb  = 4'b1111;
        oack = 1'b1;
        ngot = 0;
        for (int c = 0; c < 40 && ngot < 6; c++) begin
            step();
            if (ostb) begin
                got_ch[ngot]  = int'(och);
                got_cyc[ngot] = c;
                check($sformatf("rr%0d_data", ngot), odata, 32'hA0 + 32'(och));
                ngot++;
            end
        end
        check("rr_count", ngot, 6);
        for (int i = 0; i < ngot; i++) begin
            check($sformatf("rr%0d_ch", i), got_ch[i], i % N);
            if (i > 0) check($sformatf("rr%0d_gap", i), got_cyc[i] - got_cyc[i-1], 3);
        end

        // Output stall: SEND holds its word while inputs churn
        do_reset();
        for (int i = 0; i < N; i++) words[i] = chan_word(i);
        stb = 4'b0010;
        for (int i = 0; i < 5 && !ostb; i++) step();
        check("stall_enter", ostb, 1);
        held_data = odata;
        held_ch   = och;
        check("stall_ch", held_ch, 1);
        check("stall_data", held_data, chan_word(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stb = 4'b1111;
            for (int k = 0; k < N; k++) words[k] = $urandom;
            step();
            check("stall_iack", iack, 0);
            check("stall_ostb", ostb, 1);
            check("stall_hold_data", odata, held_data);
            check("stall_hold_ch", och, held_ch);
        end
        @(negedge clk);
        stb  = '0;
        oack = 1'b1;
        step();
        check("stall_release", ostb, 0);

        // Asynchronous reset while a word is held in SEND
        do_reset();
        for (int i = 0; i < N; i++) words[i] = chan_word(i);
        stb  = 4'b0100;
        oack = 1'b1;
        step();
        step();
        check("arst_pre_ch2", ostb, 1);
        @(negedge clk);
        stb = '0;
        step();
        check("arst_pre_idle", ostb, 0);
        @(negedge clk);
        words[1] = 32'hDEAD_BEEF;
        stb      = 4'b0010;
        oack     = 1'b0;
        step();
        check("arst_grant1", iack, 4'b0010);
        step();
        check("arst_send", odata, 32'hDEAD_BEEF);
        stb = '0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_ostb", ostb, 0);
        check("arst_odata", odata, 0);
        check("arst_och", och, 0);
        check("arst_iack", iack, 0);
        @(negedge clk);
        rst  = 1'b0;
        oack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_discard", ostb, 0);
        end
        @(negedge clk);
        stb = 4'b1001;
        step();
        check("arst_ptr0", iack, 4'b0001);

        // Watchdog: TIMEOUT=8 stalled SEND cycles
        do_reset();
        stb = 4'b0001;
        step();
        step();
        check("wd_send", ostb, 1);
        @(negedge clk);
        stb = '0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) check("wd_before", exc, 0);
            if (i == 8) check("wd_trip", exc, WdEn);
        end
        @(negedge clk);
        oack = 1'b1;
        step();
        step();
        check("wd_sticky", exc, WdEn);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            stb  = N'($urandom_range(0, 15));
            oack = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) words[k] = $urandom;
            @(posedge clk);
            model_edge();
            #1;
            exp_iack = '0;
            if (m_grant >= 0) exp_iack[m_grant] = 1'b1;
            check("rnd_iack", iack, exp_iack);
            check("rnd_ostb", ostb, held_q.size() != 0);
            if (held_q.size() != 0) begin
                check("rnd_och", och, held_q[0].ch);
                check("rnd_odata", odata, held_q[0].data);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
